// File: rtl/sum_capture_pkg.sv
// Shared constants for the adder sum capture buffer.
package sum_capture_pkg;
  localparam int unsigned SUM_W         = 33;
  localparam int unsigned CARRY_CNT_W   = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam logic [CARRY_CNT_W-1:0] CARRY_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/sum_capture_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module sum_capture_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sum_capture_fifo.sv
// Registered capture FIFO behind the 32-bit carry-select adder.
// Optional carry-out event counter enabled by `SUM_CAPTURE_CARRY_CNT_EN.
module sum_capture_fifo
  import sum_capture_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = SUM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         sum_in,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef SUM_CAPTURE_CARRY_CNT_EN
  ,
  output logic [CARRY_CNT_W-1:0]   carry_cnt
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push, pop;

  // Full/empty come from the registered count only, so no input reaches an output.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? rdata : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  sum_capture_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(sum_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (in_valid && !in_ready) ovf <= 1'b1;
      else if (ovf_clr)          ovf <= 1'b0;
    end
  end

`ifdef SUM_CAPTURE_CARRY_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (push && sum_in[WIDTH-1] && (carry_cnt != CARRY_CNT_MAX)) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/sum_capture_fifo.md
# sum_capture_fifo

Registered capture buffer directly downstream of the 32-bit carry-select adder. Each cycle that `in_valid` is high, it samples the adder's combinational 33-bit sum (carry-out in bit 32). It holds up to DEPTH results and hands them to the consumer over a valid/ready interface. It also flags dropped results and can optionally count carry-out events.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- WIDTH, 33: entry width; bit WIDTH-1 is the adder carry-out.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  `sum_in` holds a result this cycle.
- sum_in  in  WIDTH  adder sum output, {cout, sum[31:0]}.
- in_ready  out  1  high when `count < DEPTH`.
- out_valid  out  1  high when `count > 0`.
- out_data  out  WIDTH  entry at the read pointer; all zeros whenever `out_valid` is 0.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- ovf  out  1  sticky flag: a result was dropped because the buffer was full.
- ovf_clr  in  1  synchronous clear of `ovf`.
- carry_cnt  out  16  number of accepted entries with bit WIDTH-1 set. Present only when `SUM_CAPTURE_CARRY_CNT_EN` is defined.

## Operation
- **Push:** occurs when `in_valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- **Pop:** occurs when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- **Count update:** push only gives +1; pop only gives −1; push and pop together leave `count` unchanged.
- **Empty:** there is no bypass. A result pushed into an empty buffer appears on `out_data` one cycle later.
- **Full:** `in_ready` is 0, so no push happens, even if a pop occurs in the same cycle. `in_ready` rises in the cycle after the pop.
- **Overflow:** if `in_valid && !in_ready`, the data is dropped and `ovf` is set next cycle.
  - Overflow and `ovf_clr` in the same cycle: set wins.
  - Overflow never changes the pointers or the stored data.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are decided by `count`, never by pointer equality.
- **Reset:** asserting `rst_n` low at any time, including mid-stream, immediately sets:
  - `wr_ptr`, `rd_ptr` and `count` to 0;
  - `out_valid`, `ovf` and `carry_cnt` to 0;
  - `out_data` to 0 and `in_ready` to 1.
  - Storage contents are not reset and are unobservable, because `out_data` is masked while `out_valid` is 0.

## Timing
- Push to `out_valid` latency: 1 cycle when empty. Otherwise it is ordered behind older entries (FIFO order).
- `in_ready`, `out_valid`, `out_data` and `count` derive from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Maximum throughput is one push and one pop per cycle while `0 < count < DEPTH`.
- `sum_in` is sampled at the clock edge. The adder's combinational delay must settle within the same cycle.

## Configuration
- **Macro:** `SUM_CAPTURE_CARRY_CNT_EN`.
- **Defined:**
  - The `carry_cnt` port and a 16-bit counter exist.
  - The counter increments on each accepted push with `sum_in[WIDTH-1]` = 1.
  - It saturates at 16'hFFFF, is reset to 0 by `rst_n`, and is unaffected by `ovf_clr`.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- **Package `sum_capture_pkg`:**
  - SUM_W = 33;
  - CARRY_CNT_W = 16;
  - DEFAULT_DEPTH = 4;
  - CARRY_CNT_MAX = 16'hFFFF.
- **Sub-module `sum_capture_mem`:**
  - DEPTH×WIDTH register array;
  - one synchronous write port (`we`, `waddr`, `wdata`);
  - one asynchronous read port (`raddr`, `rdata`);
  - no reset.
- The top level holds the pointers, count, flags, the optional counter and the output masking.

## Test plan
- **Reset and single push:** after reset, outputs are `out_valid`=0, `out_data`=0, `in_ready`=1, `count`=0. Push 33'h0_0000_0005 → next cycle `out_valid`=1, `out_data`=33'h0_0000_0005, `count`=1.
- **Fill to full:** push 1, 2, 3, 4 with `out_ready`=0 → `count`=4, `in_ready`=0. Then pop four times → data arrives in order 1, 2, 3, 4 and `out_valid`=0 afterwards.
- **Overflow:** when full, drive `in_valid` with 33'h1_FFFF_FFFF → `ovf`=1, `count` stays 4, and no entry equals that value. Assert `ovf_clr` alone → `ovf`=0. Assert `ovf_clr` together with a further overflow → `ovf` remains 1.
- **Streaming wrap:** hold `in_valid` and `out_ready` high for 10 cycles with incrementing data → `count` settles at 1, output equals the input delayed by 1 cycle, and pointers wrap twice without loss.
- **Reset mid-stream:** with `count`=3, pull `rst_n` low asynchronously → `out_valid`, `count` and `ovf` go to 0 without waiting for a clock edge.
- **Carry count (macro defined):** push 33'h1_0000_0000, 33'h0_0000_0001, 33'h1_0000_0002 → `carry_cnt`=2. Preload the counter near saturation and push more carry entries → it holds at 16'hFFFF.
